// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: DIV/DIVU sequencer, 32-step restoring divide + sign fix, result held until ack; 35 cycles start-to-result.
// Define DIV_EARLY_EXIT_EN to skip iteration when divisor is 0 or |dividend| < |divisor| (3-cycle latency).
module div_seq_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        cancel,
  input  logic        result_ack,
  output logic        div_busy,
  output logic        div_complete,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t      r_state;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_quot;
  logic [31:0] r_rem_out;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic        r_signed;
  logic [31:0] r_q;
  logic [31:0] r_prem;
  logic [31:0] r_dvs;
  logic [5:0]  r_cnt;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_div0;

  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_shift;
  logic [32:0] w_trial;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;
  logic        w_skip;

  // |0x8000_0000| wraps back to itself and is then treated as unsigned.
  assign w_abs_a = (r_signed && r_op_a[31]) ? (32'd0 - r_op_a) : r_op_a;
  assign w_abs_b = (r_signed && r_op_b[31]) ? (32'd0 - r_op_b) : r_op_b;

  assign w_shift = {r_prem, r_q[31]};
  assign w_trial = w_shift - {1'b0, r_dvs};

  assign w_q_fix = r_neg_q ? (32'd0 - r_q)    : r_q;
  assign w_r_fix = r_neg_r ? (32'd0 - r_prem) : r_prem;

`ifdef DIV_EARLY_EXIT_EN
  assign w_skip = (r_op_b == 32'd0) || (w_abs_a < w_abs_b);
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_quot    <= 32'd0;
      r_rem_out <= 32'd0;
      r_op_a    <= 32'd0;
      r_op_b    <= 32'd0;
      r_signed  <= 1'b0;
      r_q       <= 32'd0;
      r_prem    <= 32'd0;
      r_dvs     <= 32'd0;
      r_cnt     <= 6'd0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_div0    <= 1'b0;
    end else if (cancel) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (div_start) begin
            r_op_a   <= dividend;
            r_op_b   <= divisor;
            r_signed <= div_signed;
            r_busy   <= 1'b1;
            r_state  <= S_PREP;
          end
        end
        S_PREP: begin
          r_dvs   <= w_abs_b;
          r_neg_q <= r_signed & (r_op_a[31] ^ r_op_b[31]);
          r_neg_r <= r_signed & r_op_a[31];
          r_div0  <= (r_op_b == 32'd0);
          r_cnt   <= 6'd0;
          if (w_skip) begin
            r_q     <= 32'd0;
            r_prem  <= w_abs_a;
            r_state <= S_FIX;
          end else begin
            r_q     <= w_abs_a;
            r_prem  <= 32'd0;
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          if (!w_trial[32]) begin
            r_prem <= w_trial[31:0];
            r_q    <= {r_q[30:0], 1'b1};
          end else begin
            r_prem <= w_shift[31:0];
            r_q    <= {r_q[30:0], 1'b0};
          end
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          // Divide-by-zero returns a fixed pattern with no sign correction.
          if (r_div0) begin
            r_quot    <= 32'hFFFF_FFFF;
            r_rem_out <= r_op_a;
          end else begin
            r_quot    <= w_q_fix;
            r_rem_out <= w_r_fix;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (result_ack) begin
            r_done <= 1'b0;
            if (div_start) begin
              r_op_a   <= dividend;
              r_op_b   <= divisor;
              r_signed <= div_signed;
              r_busy   <= 1'b1;
              r_state  <= S_PREP;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign div_busy     = r_busy;
  assign div_complete = r_done;
  assign quotient     = r_quot;
  assign remainder    = r_rem_out;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: stimulus queues hand-computed results, a negedge monitor checks them.
module tb_div_seq_ctrl;

`ifdef DIV_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        div_start;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        cancel;
  logic        result_ack;
  logic        div_busy;
  logic        div_complete;
  logic [31:0] quotient;
  logic [31:0] remainder;

  div_seq_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .div_start    (div_start),
    .div_signed   (div_signed),
    .dividend     (dividend),
    .divisor      (divisor),
    .cancel       (cancel),
    .result_ack   (result_ack),
    .div_busy     (div_busy),
    .div_complete (div_complete),
    .quotient     (quotient),
    .remainder    (remainder)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          start;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
    end
  endtask

  // Monitor: on each rising div_complete pop one expectation and compare.
  logic prev_c = 1'b0;
  logic prev_b = 1'b0;
  int   bcnt   = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      prev_c = 1'b0;
      prev_b = 1'b0;
      bcnt   = 0;
    end else begin
      if (div_busy) bcnt = prev_b ? bcnt + 1 : 1;
      if (div_complete && !prev_c) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_complete: got q=0x%08h r=0x%08h, expected no result", quotient, remainder);
        end else begin
          e = sb.pop_front();
          check("quotient", quotient, e.q);
          check("remainder", remainder, e.r);
          check("latency", 32'(cyc - e.start), 32'(e.lat));
          check("busy_cycles", 32'(bcnt), 32'(e.lat));
        end
      end
      prev_c = div_complete;
      prev_b = div_busy;
    end
  end

  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er,
                          input bit short_path, input bit push, input bit with_ack);
    exp_t e;
    @(negedge clk);
    div_start  = 1'b1;
    div_signed = sgn;
    dividend   = a;
    divisor    = b;
    result_ack = with_ack;
    @(posedge clk);
    #1;
    if (push) begin
      e.q     = eq;
      e.r     = er;
      e.start = cyc;
      e.lat   = (EARLY && short_path) ? 2 : 34;
      sb.push_back(e);
    end
    div_start  = 1'b0;
    result_ack = 1'b0;
    dividend   = $urandom;
    divisor    = $urandom;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!div_complete && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (!div_complete) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got div_complete=0 after %0d cycles, expected 1", nm, n);
    end
  endtask

  task automatic ack();
    @(negedge clk);
    result_ack = 1'b1;
    @(posedge clk);
    #1;
    result_ack = 1'b0;
    check("ack_drop_complete", {31'd0, div_complete}, 32'd0);
  endtask

  task automatic do_op(input string nm, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input bit short_path);
    start_op(sgn, a, b, eq, er, short_path, 1'b1, 1'b0);
    wait_done(nm);
    ack();
  endtask

  initial begin
    resetn     = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    dividend   = 32'd0;
    divisor    = 32'd0;
    cancel     = 1'b0;
    result_ack = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'd0, div_busy}, 32'd0);
    check("rst_complete", {31'd0, div_complete}, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);

    // DIVU 7/2 with result held for several cycles before ack.
    start_op(1'b0, 32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 1'b1, 1'b0);
    wait_done("divu_7_2");
    repeat (3) @(negedge clk);
    check("hold_complete", {31'd0, div_complete}, 32'd1);
    check("hold_quotient", quotient, 32'd3);
    check("hold_remainder", remainder, 32'd1);
    ack();

    do_op("div_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    do_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0);
    do_op("div_by_0",   1'b1, 32'h1234_5678, 32'd0,        32'hFFFF_FFFF, 32'h1234_5678, 1'b1);

    // Cancel during ITER step 10: started without an expectation.
    start_op(1'b1, 32'h0000_4321, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (11) @(posedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", {31'd0, div_busy}, 32'd0);
    check("cancel_complete", {31'd0, div_complete}, 32'd0);
    repeat (40) @(negedge clk);
    check("cancel_no_complete", {31'd0, div_complete}, 32'd0);

    // DIVU 100/7, then back-to-back ack+start DIVU 9/3.
    start_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1, 1'b0);
    wait_done("divu_100_7");
    start_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1, 1'b1);
    check("b2b_complete_low", {31'd0, div_complete}, 32'd0);
    check("b2b_busy_high", {31'd0, div_busy}, 32'd1);
    wait_done("divu_9_3");
    ack();

    do_op("divu_3_10",  1'b0, 32'd3, 32'd10,           32'd0,         32'd3,         1'b1);
    do_op("div_7_m2",   1'b1, 32'd7, 32'hFFFF_FFFE,     32'hFFFF_FFFD, 32'd1,         1'b0);

    // Asynchronous reset in the middle of ITER clears outputs at once.
    start_op(1'b0, 32'hDEAD_BEEF, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("arst_busy", {31'd0, div_busy}, 32'd0);
    check("arst_complete", {31'd0, div_complete}, 32'd0);
    check("arst_quotient", quotient, 32'd0);
    check("arst_remainder", remainder, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    check("arst_no_complete", {31'd0, div_complete}, 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
